// File: rtl/register_port_sequencer_pkg.sv
// Shared CPU package: register bank geometry, sequencer states and
// the latched transaction bundles used by the register port sequencer.
package register_port_sequencer_pkg;

    localparam int REG_COUNT = 16;
    localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
    localparam int DATA_WIDTH = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [3:0] {
        IDLE,
        RD1,
        RD2,
        CAP2,
        WR,
        DRD,
        DCAP,
        DWR,
        ACK
    } state_t;

    typedef enum logic {
        GRANT_CORE = 1'b0,
        GRANT_DBG  = 1'b1
    } grant_t;

    typedef struct packed {
        reg_addr_t rs1;
        reg_addr_t rs2;
        reg_addr_t rd;
        logic      wr_en;
        data_t     wr_data;
    } core_txn_t;

    typedef struct packed {
        reg_addr_t rn;
        data_t     wr_data;
    } dbg_txn_t;

    // Register 0 is hard-wired zero, so a write there is never issued.
    function automatic logic writes_reg(logic en, reg_addr_t rn);
        return en && (rn != REG_ZERO);
    endfunction

endpackage

// File: rtl/register_port_sequencer_if.sv
// Core, debug and bank signals of the register port sequencer.
// The sequencer takes the slave view; requesters and bank the master view.
interface register_port_sequencer_if;
    import register_port_sequencer_pkg::*;

    logic      coreReq;
    reg_addr_t coreRs1;
    reg_addr_t coreRs2;
    reg_addr_t coreRd;
    logic      coreWrEn;
    data_t     coreWrData;
    logic      coreAck;
    data_t     coreRs1Data;
    data_t     coreRs2Data;

    logic      dbgReq;
    logic      dbgWe;
    reg_addr_t dbgReg;
    data_t     dbgWrData;
    logic      dbgAck;
    data_t     dbgRdData;

    reg_addr_t bankRegNum;
    data_t     bankDataIn;
    logic      bankWriteEnable;
    data_t     bankDataOut;

    modport slave (
        input  coreReq, coreRs1, coreRs2, coreRd,
        input  coreWrEn, coreWrData,
        output coreAck, coreRs1Data, coreRs2Data,
        input  dbgReq, dbgWe, dbgReg, dbgWrData,
        output dbgAck, dbgRdData,
        output bankRegNum, bankDataIn, bankWriteEnable,
        input  bankDataOut
    );

    modport master (
        output coreReq, coreRs1, coreRs2, coreRd,
        output coreWrEn, coreWrData,
        input  coreAck, coreRs1Data, coreRs2Data,
        output dbgReq, dbgWe, dbgReg, dbgWrData,
        input  dbgAck, dbgRdData,
        input  bankRegNum, bankDataIn, bankWriteEnable,
        output bankDataOut
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter between core and debug.
// On a tie the requester not granted last wins; history starts at debug.
module rr_arbiter2
    import register_port_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_core,
    input  logic req_dbg,
    output logic grant_core,
    output logic grant_dbg
);

    grant_t last_grant;

    always_comb begin
        grant_core = en && req_core
                     && (!req_dbg || last_grant == GRANT_DBG);
        grant_dbg  = en && req_dbg && !grant_core;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_DBG;
        end else if (grant_core) begin
            last_grant <= GRANT_CORE;
        end else if (grant_dbg) begin
            last_grant <= GRANT_DBG;
        end
    end

endmodule

// File: rtl/register_port_sequencer.sv
// Time-shares the single-port register bank between the core pipeline
// (two reads plus optional write) and single-register debug accesses.
module register_port_sequencer
    import register_port_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    register_port_sequencer_if.slave bus
);

    state_t    state;
    state_t    state_next;
    core_txn_t core_q;
    dbg_txn_t  dbg_q;
    logic      dbg_active;
    data_t     rs1_cap;
    data_t     rs2_cap;
    data_t     rs1_out;
    data_t     rs2_out;
    data_t     dbg_rd;
    logic      grant_core;
    logic      grant_dbg;
    logic      arb_en;

    assign arb_en = (state == IDLE);

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .en         (arb_en),
        .req_core   (bus.coreReq),
        .req_dbg    (bus.dbgReq),
        .grant_core (grant_core),
        .grant_dbg  (grant_dbg)
    );

    always_comb begin
        state_next          = state;
        bus.bankRegNum      = REG_ZERO;
        bus.bankDataIn      = '0;
        bus.bankWriteEnable = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_core) begin
                    state_next = RD1;
                end else if (grant_dbg) begin
                    state_next = bus.dbgWe ? DWR : DRD;
                end
            end
            RD1: begin
                bus.bankRegNum = core_q.rs1;
                state_next     = RD2;
            end
            RD2: begin
                bus.bankRegNum = core_q.rs2;
                state_next     = CAP2;
            end
            CAP2: begin
                state_next = writes_reg(core_q.wr_en, core_q.rd)
                             ? WR : ACK;
            end
            WR: begin
                bus.bankRegNum      = core_q.rd;
                bus.bankDataIn      = core_q.wr_data;
                bus.bankWriteEnable = 1'b1;
                state_next          = ACK;
            end
            DRD: begin
                bus.bankRegNum = dbg_q.rn;
                state_next     = DCAP;
            end
            DCAP: begin
                state_next = ACK;
            end
            DWR: begin
                bus.bankRegNum      = dbg_q.rn;
                bus.bankDataIn      = dbg_q.wr_data;
                bus.bankWriteEnable = writes_reg(1'b1, dbg_q.rn);
                state_next          = ACK;
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            core_q     <= '0;
            dbg_q      <= '0;
            dbg_active <= 1'b0;
            rs1_cap    <= '0;
            rs2_cap    <= '0;
            rs1_out    <= '0;
            rs2_out    <= '0;
            dbg_rd     <= '0;
        end else begin
            state <= state_next;
            if (grant_core) begin
                core_q.rs1     <= bus.coreRs1;
                core_q.rs2     <= bus.coreRs2;
                core_q.rd      <= bus.coreRd;
                core_q.wr_en   <= bus.coreWrEn;
                core_q.wr_data <= bus.coreWrData;
                dbg_active     <= 1'b0;
            end else if (grant_dbg) begin
                dbg_q.rn      <= bus.dbgReg;
                dbg_q.wr_data <= bus.dbgWrData;
                dbg_active    <= 1'b1;
            end
            if (state == RD2) begin
                rs1_cap <= bus.bankDataOut;
            end
            if (state == CAP2) begin
                rs2_cap <= bus.bankDataOut;
            end
            // Results become visible together, on entry to the ack cycle.
            if (state == CAP2 && state_next == ACK) begin
                rs1_out <= rs1_cap;
                rs2_out <= bus.bankDataOut;
            end
            if (state == WR) begin
                rs1_out <= rs1_cap;
                rs2_out <= rs2_cap;
            end
            if (state == DCAP) begin
                dbg_rd <= bus.bankDataOut;
            end
        end
    end

    assign bus.coreAck     = (state == ACK) && !dbg_active;
    assign bus.dbgAck      = (state == ACK) && dbg_active;
    assign bus.coreRs1Data = rs1_out;
    assign bus.coreRs2Data = rs2_out;
    assign bus.dbgRdData   = dbg_rd;

endmodule

// File: tb/tb_register_port_sequencer.sv
// Directed bench for register_port_sequencer with a behavioural
// 16 x 32 registered-read bank model attached to the bank port.
module tb_register_port_sequencer;
    import register_port_sequencer_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic we_hi;
    data_t mem [REG_COUNT];

    register_port_sequencer_if bus ();

    register_port_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: registered read of the old value, reg 0 reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
            bus.bankDataOut <= '0;
        end else begin
            if (bus.bankWriteEnable && bus.bankRegNum != REG_ZERO)
                mem[bus.bankRegNum] <= bus.bankDataIn;
            bus.bankDataOut <= (bus.bankRegNum == REG_ZERO)
                               ? '0 : mem[bus.bankRegNum];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic core_req(input reg_addr_t rs1,
                            input reg_addr_t rs2,
                            input reg_addr_t rd,
                            input logic wr_en,
                            input data_t data);
        bus.coreRs1    = rs1;
        bus.coreRs2    = rs2;
        bus.coreRd     = rd;
        bus.coreWrEn   = wr_en;
        bus.coreWrData = data;
        bus.coreReq    = 1'b1;
    endtask

    task automatic dbg_req(input logic we,
                           input reg_addr_t rn,
                           input data_t data);
        bus.dbgWe     = we;
        bus.dbgReg    = rn;
        bus.dbgWrData = data;
        bus.dbgReq    = 1'b1;
    endtask

    // Counts falling edges until the wanted ack; flags a stray other ack.
    task automatic wait_ack(input logic dbg,
                            input int lat,
                            input string tag);
        int   n;
        logic other;
        logic hit;
        n     = 0;
        other = 1'b0;
        hit   = 1'b0;
        while (!hit && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.bankWriteEnable) we_hi = 1'b1;
            if (dbg ? bus.coreAck : bus.dbgAck) other = 1'b1;
            hit = dbg ? bus.dbgAck : bus.coreAck;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_order"}, {31'd0, other}, 32'd0);
    endtask

    initial begin
        int nz;
        n_vec = 0;
        n_err = 0;
        we_hi = 1'b0;
        reset = 1'b1;
        bus.coreReq = 1'b0;
        bus.coreRs1 = '0;
        bus.coreRs2 = '0;
        bus.coreRd = '0;
        bus.coreWrEn = 1'b0;
        bus.coreWrData = '0;
        bus.dbgReq = 1'b0;
        bus.dbgWe = 1'b0;
        bus.dbgReg = '0;
        bus.dbgWrData = '0;

        repeat (2) @(negedge clk);
        check("rst_core_ack", {31'd0, bus.coreAck}, 32'd0);
        check("rst_dbg_ack", {31'd0, bus.dbgAck}, 32'd0);
        check("rst_we", {31'd0, bus.bankWriteEnable}, 32'd0);
        check("rst_regnum", {28'd0, bus.bankRegNum}, 32'd0);
        check("rst_datain", bus.bankDataIn, 32'd0);
        check("rst_rs1", bus.coreRs1Data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Core write then read-back of the written register
        core_req(4'd1, 4'd2, 4'd3, 1'b1, 32'hFFFF_FFFF);
        wait_ack(1'b0, 5, "wr3");
        check("wr3_rs1", bus.coreRs1Data, 32'h0);
        check("wr3_rs2", bus.coreRs2Data, 32'h0);
        check("wr3_bank", mem[3], 32'hFFFF_FFFF);
        bus.coreReq = 1'b0;
        @(negedge clk);
        check("ack_pulse", {31'd0, bus.coreAck}, 32'd0);

        core_req(4'd3, 4'd0, 4'd0, 1'b0, 32'h0);
        wait_ack(1'b0, 4, "rd3");
        check("rd3_rs1", bus.coreRs1Data, 32'hFFFF_FFFF);
        check("rd3_rs2", bus.coreRs2Data, 32'h0);
        bus.coreReq = 1'b0;
        @(negedge clk);

        // Read-before-write on the same register
        dbg_req(1'b1, 4'd5, 32'h0000_000A);
        wait_ack(1'b1, 2, "dwr5");
        check("dwr5_bank", mem[5], 32'h0000_000A);
        bus.dbgReq = 1'b0;
        @(negedge clk);

        core_req(4'd5, 4'd3, 4'd5, 1'b1, 32'h0000_0014);
        wait_ack(1'b0, 5, "rbw");
        check("rbw_rs1", bus.coreRs1Data, 32'h0000_000A);
        check("rbw_rs2", bus.coreRs2Data, 32'hFFFF_FFFF);
        check("rbw_bank", mem[5], 32'h0000_0014);
        bus.coreReq = 1'b0;
        @(negedge clk);

        // Register 0 write is suppressed
        we_hi = 1'b0;
        core_req(4'd0, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFF);
        wait_ack(1'b0, 4, "wr0");
        check("wr0_we", {31'd0, we_hi}, 32'd0);
        check("wr0_bank", mem[0], 32'h0);
        check("wr0_rs1", bus.coreRs1Data, 32'h0);
        bus.coreReq = 1'b0;
        @(negedge clk);

        // Tie-breaking and alternation
        dbg_req(1'b1, 4'd7, 32'h1234_5678);
        wait_ack(1'b1, 2, "dwr7");
        check("dwr7_bank", mem[7], 32'h1234_5678);
        bus.dbgReq = 1'b0;
        @(negedge clk);

        core_req(4'd7, 4'd3, 4'd0, 1'b0, 32'h0);
        dbg_req(1'b0, 4'd7, 32'h0);
        wait_ack(1'b0, 4, "tie1_core");
        check("tie1_rs1", bus.coreRs1Data, 32'h1234_5678);
        check("tie1_rs2", bus.coreRs2Data, 32'hFFFF_FFFF);
        core_req(4'd7, 4'd3, 4'd9, 1'b1, 32'h0000_0099);
        wait_ack(1'b1, 4, "tie1_dbg");
        check("tie1_dbgrd", bus.dbgRdData, 32'h1234_5678);
        dbg_req(1'b1, 4'd10, 32'h0000_00AA);
        wait_ack(1'b0, 6, "tie2_core");
        check("tie2_bank9", mem[9], 32'h0000_0099);
        check("tie2_rs1", bus.coreRs1Data, 32'h1234_5678);
        bus.coreReq = 1'b0;
        wait_ack(1'b1, 3, "tie2_dbg");
        check("tie2_bank10", mem[10], 32'h0000_00AA);
        bus.dbgReq = 1'b0;
        @(negedge clk);

        // Reset asserted during the write cycle
        core_req(4'd1, 4'd2, 4'd4, 1'b1, 32'h0000_0044);
        repeat (4) @(negedge clk);
        check("wr_cycle_we", {31'd0, bus.bankWriteEnable}, 32'd1);
        check("wr_cycle_rn", {28'd0, bus.bankRegNum}, 32'd4);
        reset = 1'b1;
        bus.coreReq = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, bus.bankWriteEnable}, 32'd0);
        check("mid_rst_rn", {28'd0, bus.bankRegNum}, 32'd0);
        check("mid_rst_din", bus.bankDataIn, 32'd0);
        check("mid_rst_ack", {31'd0, bus.coreAck}, 32'd0);
        check("mid_rst_rs1", bus.coreRs1Data, 32'd0);
        check("mid_rst_dbgrd", bus.dbgRdData, 32'd0);
        nz = 0;
        for (int i = 0; i < REG_COUNT; i++)
            if (mem[i] != '0) nz++;
        check("mid_rst_bank", nz, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        we_hi = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.coreAck || bus.bankWriteEnable) we_hi = 1'b1;
        end
        check("post_rst_quiet", {31'd0, we_hi}, 32'd0);
        check("post_rst_bank4", mem[4], 32'd0);

        // Back-to-back core writes to registers 1..15
        for (int i = 1; i < REG_COUNT; i++) begin
            core_req(reg_addr_t'(i - 1), reg_addr_t'(i),
                     reg_addr_t'(i), 1'b1, 32'h100 + i);
            wait_ack(1'b0, (i == 1) ? 5 : 6, "b2b");
            check("b2b_rs1", bus.coreRs1Data,
                  (i == 1) ? 32'h0 : 32'h100 + i - 1);
            check("b2b_rs2", bus.coreRs2Data, 32'h0);
        end
        bus.coreReq = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i < REG_COUNT; i++)
            check("b2b_bank", mem[i], 32'h100 + i);
        check("b2b_bank0", mem[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
